udma_adc_ch_demux: RTL and testbench
====================================

// Module: udma_adc_ch_demux
// PURPOSE
//   Sits between the ADC sampling front-end and the per-channel uDMA RX ports of the ADC RX channel.
//   Accepts channel-tagged ADC samples (strobe, no backpressure) and buffers them in an input FIFO.
//   Routes each sample to the uDMA RX data port of its channel with a valid/ready handshake.
//   Applies single-channel mode and channel-enable gating, and counts dropped or overflowed samples.
// PARAMETERS
//   ADC_NUM_CHS     8   number of logical ADC channels / uDMA RX ports
//   ADC_DATA_WIDTH  12  ADC sample width (<= 24)
//   ADC_ID_WIDTH    4   width of channel tag from front-end (2**ADC_ID_WIDTH >= ADC_NUM_CHS)
//   FIFO_DEPTH      4   input FIFO entries, power of 2, >= 2
// PORTS
//   clk_i                 in   1                  system clock
//   rstn_i                in   1                  asynchronous reset, active low
//   adc_valid_i           in   1                  one-cycle sample strobe
//   adc_data_i            in   ADC_DATA_WIDTH     sample value
//   adc_ch_i              in   ADC_ID_WIDTH       channel tag of sample
//   cfg_single_ch_mode_i  in   1                  1: all samples go to channel 0
//   cfg_rx_en_i           in   ADC_NUM_CHS        per-channel uDMA RX enabled
//   ovf_clr_i             in   1                  clears overflow_o and drop_cnt_o
//   data_rx_o             out  ADC_NUM_CHS x 32   per-channel RX data word
//   data_rx_valid_o       out  ADC_NUM_CHS        per-channel RX valid
//   data_rx_ready_i       in   ADC_NUM_CHS        per-channel RX ready
//   data_rx_datasize_o    out  2                  constant 2'b10 (32-bit words)
//   overflow_o            out  1                  sticky: sample lost on full FIFO
//   drop_cnt_o            out  16                 saturating count of dropped samples
// BEHAVIOUR
//   Reset: FIFO empty, FSM IDLE, data_rx_o=0, data_rx_valid_o=0, overflow_o=0, drop_cnt_o=0.
//   Push: adc_valid_i writes {adc_ch_i, adc_data_i} at next edge if FIFO not full, or if full and a
//     pop occurs in the same cycle. Otherwise the sample is lost, overflow_o<=1, drop_cnt_o+1.
//   Target channel: 0 if cfg_single_ch_mode_i=1, else the FIFO head tag (sampled at pop time).
//   Data word: [ADC_DATA_WIDTH-1:0]=sample, [31:28]=original tag (low 4 bits, zero-padded), rest 0.
//   FSM IDLE: if FIFO non-empty, pop head. If target < ADC_NUM_CHS and cfg_rx_en_i[target]=1,
//     load output register and go to SEND. Else discard and drop_cnt_o+1 (one pop per cycle).
//   FSM SEND: data_rx_valid_o[target]=1 only; data_rx_o[target]=word; word stable until handshake.
//     valid&ready: transfer. If FIFO non-empty, pop and load next head the same cycle (no bubble,
//     1 word/cycle), with the same routing/discard rules as IDLE. Else go to IDLE.
//     cfg_rx_en_i[target] falls while SEND and no handshake: word discarded, drop_cnt_o+1, IDLE.
//   Latency: strobe at cycle T, idle and empty -> data_rx_valid_o asserted from cycle T+2.
//   Non-selected data_rx_o lanes drive 0. Mode change applies only to words popped afterwards.
//   drop_cnt_o saturates at 16'hFFFF. ovf_clr_i zeroes both; a drop in the same cycle wins
//     (overflow_o=1, drop_cnt_o=1).
//   Two drops in one cycle (overflow push + discarded pop) add 2.
// TESTING
//   Ch3 tag, data 12'hABC, ready=1, en=all -> data_rx_valid_o[3] at T+2, data_rx_o[3]=32'h3000_0ABC.
//   Single-ch mode, tags 5,6 -> both words on lane 0, bits[31:28]=5 then 6, lanes 5/6 stay idle.
//   Ready[1]=0, 6 strobes to ch1, DEPTH=4 -> 4 buffered + 1 in SEND, 1 lost, overflow_o=1, cnt=1.
//   cfg_rx_en_i[2]=0, sample to ch2 -> never valid, drop_cnt_o=1. Tag 9 with 8 channels -> dropped.
//   Ready=1 continuously, 4 back-to-back strobes -> 4 consecutive valid cycles, no bubble.
//   rstn_i low while SEND with 3 buffered -> all valids 0 at once, FIFO empty, counters 0.

Source files
------------

// File: rtl/udma_adc_ch_demux.sv
// Channel demultiplexer between the ADC sampling front-end and the per-channel uDMA RX ports.
// Samples are buffered in a small FIFO and then routed with valid/ready, one word per cycle.
module udma_adc_ch_demux #(
  parameter int unsigned ADC_NUM_CHS    = 8,
  parameter int unsigned ADC_DATA_WIDTH = 12,
  parameter int unsigned ADC_ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                adc_valid_i,
  input  logic [ADC_DATA_WIDTH-1:0]           adc_data_i,
  input  logic [ADC_ID_WIDTH-1:0]             adc_ch_i,
  input  logic                                cfg_single_ch_mode_i,
  input  logic [ADC_NUM_CHS-1:0]              cfg_rx_en_i,
  input  logic                                ovf_clr_i,
  output logic [ADC_NUM_CHS-1:0][31:0]        data_rx_o,
  output logic [ADC_NUM_CHS-1:0]              data_rx_valid_o,
  input  logic [ADC_NUM_CHS-1:0]              data_rx_ready_i,
  output logic [1:0]                          data_rx_datasize_o,
  output logic                                overflow_o,
  output logic [15:0]                         drop_cnt_o
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CH_W    = (ADC_NUM_CHS > 1) ? $clog2(ADC_NUM_CHS) : 1;
  localparam int unsigned ENTRY_W = ADC_ID_WIDTH + ADC_DATA_WIDTH;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e                          r_state, w_state_nxt;
  logic [ENTRY_W-1:0]              r_mem [FIFO_DEPTH];
  logic [PTR_W:0]                  r_wr_ptr, r_rd_ptr;
  logic [CH_W-1:0]                 r_target;
  logic [ADC_NUM_CHS-1:0]          r_valid, w_valid_nxt;
  logic [ADC_NUM_CHS-1:0][31:0]    r_data, w_data_nxt;
  logic                            r_ovf;
  logic [CNT_W-1:0]                r_cnt;

  logic                            w_empty, w_full, w_push, w_pop, w_lost;
  logic                            w_disc, w_load, w_clear, w_hs, w_tgt_ok;
  logic [ENTRY_W-1:0]              w_head;
  logic [ADC_ID_WIDTH-1:0]         w_head_tag, w_tgt;
  logic [ADC_DATA_WIDTH-1:0]       w_head_data;
  logic [CH_W-1:0]                 w_tgt_idx;
  logic [31:0]                     w_word;
  logic [1:0]                      w_inc;
  logic [CNT_W-1:0]                w_cnt_base, w_cnt_nxt;
  logic [CNT_W:0]                  w_cnt_sum;

  // FIFO status and head decode; routing target is resolved at pop time
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_tag  = w_head[ENTRY_W-1 -: ADC_ID_WIDTH];
  assign w_head_data = w_head[ADC_DATA_WIDTH-1:0];
  assign w_tgt       = cfg_single_ch_mode_i ? '0 : w_head_tag;
  assign w_tgt_idx   = CH_W'(w_tgt);
  assign w_tgt_ok    = (32'(w_tgt) < ADC_NUM_CHS) && cfg_rx_en_i[w_tgt_idx];
  assign w_word      = {4'(w_head_tag), 28'(w_head_data)};
  assign w_hs        = r_valid[r_target] & data_rx_ready_i[r_target];

  // A full FIFO still accepts a sample when the head leaves in the same cycle
  assign w_push = adc_valid_i && (!w_full || w_pop);
  assign w_lost = adc_valid_i && !w_push;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_disc      = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_tgt_ok) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
          end else begin
            w_disc = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          if (!w_empty) begin
            w_pop = 1'b1;
            if (w_tgt_ok) begin
              w_load = 1'b1;
            end else begin
              w_disc      = 1'b1;
              w_clear     = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (!cfg_rx_en_i[r_target]) begin
          w_disc      = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    if (w_load) begin
      w_valid_nxt            = '0;
      w_data_nxt             = '0;
      w_valid_nxt[w_tgt_idx] = 1'b1;
      w_data_nxt[w_tgt_idx]  = w_word;
    end else if (w_clear) begin
      w_valid_nxt = '0;
      w_data_nxt  = '0;
    end
  end

  // Lost push and discarded pop can coincide, so the counter may step by two
  assign w_inc      = 2'(w_lost) + 2'(w_disc);
  assign w_cnt_base = ovf_clr_i ? '0 : r_cnt;
  assign w_cnt_sum  = (CNT_W+1)'(w_cnt_base) + (CNT_W+1)'(w_inc);
  assign w_cnt_nxt  = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {adc_ch_i, adc_data_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_target <= '0;
      r_valid  <= '0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_load) r_target <= w_tgt_idx;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_ovf   <= w_lost | (r_ovf & ~ovf_clr_i);
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign data_rx_o          = r_data;
  assign data_rx_valid_o    = r_valid;
  assign data_rx_datasize_o = 2'b10;
  assign overflow_o         = r_ovf;
  assign drop_cnt_o         = r_cnt;

endmodule

// File: tb/tb_udma_adc_ch_demux.sv
// Scoreboard bench for udma_adc_ch_demux: directed strobes push expected words,
// a negedge monitor pops and compares on every RX handshake.
module tb_udma_adc_ch_demux;

  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 12;
  localparam int unsigned IW  = 4;

  logic                   clk_i;
  logic                   rstn_i;
  logic                   adc_valid_i;
  logic [DW-1:0]          adc_data_i;
  logic [IW-1:0]          adc_ch_i;
  logic                   cfg_single_ch_mode_i;
  logic [NCH-1:0]         cfg_rx_en_i;
  logic                   ovf_clr_i;
  logic [NCH-1:0][31:0]   data_rx_o;
  logic [NCH-1:0]         data_rx_valid_o;
  logic [NCH-1:0]         data_rx_ready_i;
  logic [1:0]             data_rx_datasize_o;
  logic                   overflow_o;
  logic [15:0]            drop_cnt_o;

  udma_adc_ch_demux #(
    .ADC_NUM_CHS(NCH), .ADC_DATA_WIDTH(DW), .ADC_ID_WIDTH(IW), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i), .adc_ch_i(adc_ch_i),
    .cfg_single_ch_mode_i(cfg_single_ch_mode_i), .cfg_rx_en_i(cfg_rx_en_i),
    .ovf_clr_i(ovf_clr_i),
    .data_rx_o(data_rx_o), .data_rx_valid_o(data_rx_valid_o),
    .data_rx_ready_i(data_rx_ready_i), .data_rx_datasize_o(data_rx_datasize_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    int          lane;
    logic [31:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   run_len  = 0;
  int   max_run  = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every handshake must match the oldest expected word
  always @(negedge clk_i) begin : monitor
    logic [NCH-1:0] hs;
    logic           idle_zero;
    exp_t           e;
    if (rstn_i) begin
      if (data_rx_valid_o != '0) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      hs = data_rx_valid_o & data_rx_ready_i;
      if (hs != '0) begin
        check("one_hot_valid", 32'($countones(data_rx_valid_o)), 32'd1);
        idle_zero = 1'b1;
        for (int i = 0; i < int'(NCH); i++)
          if (!data_rx_valid_o[i] && data_rx_o[i] != 32'h0) idle_zero = 1'b0;
        check("idle_lanes_zero", 32'(idle_zero), 32'd1);
        for (int i = 0; i < int'(NCH); i++) begin
          if (hs[i]) begin
            if (sb_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_word: lane %0d word 0x%08h, required no transfer", i, data_rx_o[i]);
            end else begin
              e = sb_q.pop_front();
              check("lane", 32'(i), 32'(e.lane));
              check("word", data_rx_o[i], e.word);
            end
          end
        end
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic [IW-1:0] ch, input logic [DW-1:0] d);
    adc_valid_i = 1'b1;
    adc_ch_i    = ch;
    adc_data_i  = d;
    tick();
    adc_valid_i = 1'b0;
  endtask

  task automatic expect_word(input int lane, input logic [31:0] w);
    exp_t e;
    e.lane = lane;
    e.word = w;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check("drain_in_time", 32'(sb_q.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic clear_ovf();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i               = 1'b0;
    adc_valid_i          = 1'b0;
    adc_data_i           = '0;
    adc_ch_i             = '0;
    cfg_single_ch_mode_i = 1'b0;
    cfg_rx_en_i          = '1;
    ovf_clr_i            = 1'b0;
    data_rx_ready_i      = '1;
    repeat (3) tick();
    check("rst_valid", 32'(data_rx_valid_o), 32'h0);
    check("rst_data_zero", 32'(data_rx_o == '0), 32'd1);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    check("datasize", 32'(data_rx_datasize_o), 32'd2);
    rstn_i = 1'b1;
    tick();

    // Basic routing and T+2 latency
    expect_word(3, 32'h3000_0ABC);
    strobe(4'd3, 12'hABC);
    check("lat_t1_no_valid", 32'(data_rx_valid_o), 32'h0);
    tick();
    check("lat_t2_valid", 32'(data_rx_valid_o), 32'h08);
    check("lat_t2_data", data_rx_o[3], 32'h3000_0ABC);
    drain(10);

    // Single-channel mode keeps the original tag in the top nibble
    cfg_single_ch_mode_i = 1'b1;
    expect_word(0, 32'h5000_0111);
    expect_word(0, 32'h6000_0222);
    strobe(4'd5, 12'h111);
    strobe(4'd6, 12'h222);
    drain(20);
    cfg_single_ch_mode_i = 1'b0;

    // Overflow: lane 1 stalled, six back-to-back samples, last one lost
    data_rx_ready_i[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) expect_word(1, 32'h1000_0000 | 32'(k));
      strobe(4'd1, 12'(k));
    end
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt_o), 32'd1);
    check("ovf_stalled_valid", 32'(data_rx_valid_o), 32'h02);
    data_rx_ready_i[1] = 1'b1;
    drain(20);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    clear_ovf();
    check("clr_overflow", 32'(overflow_o), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt_o), 32'd0);

    // Disabled channel and out-of-range tag are discarded
    cfg_rx_en_i[2] = 1'b0;
    strobe(4'd2, 12'h222);
    repeat (4) tick();
    check("dis_drop_cnt", 32'(drop_cnt_o), 32'd1);
    check("dis_no_valid", 32'(data_rx_valid_o), 32'h0);
    strobe(4'd9, 12'h999);
    repeat (3) tick();
    check("tag9_drop_cnt", 32'(drop_cnt_o), 32'd2);
    cfg_rx_en_i = '1;
    clear_ovf();
    check("clr2_drop_cnt", 32'(drop_cnt_o), 32'd0);

    // Back-to-back throughput
    max_run = 0;
    expect_word(0, 32'h0000_0100);
    expect_word(1, 32'h1000_0101);
    expect_word(2, 32'h2000_0102);
    expect_word(3, 32'h3000_0103);
    for (int k = 0; k < 4; k++) strobe(4'(k), 12'h100 + 12'(k));
    drain(20);
    check("b2b_run", 32'(max_run), 32'd4);

    // Enable dropping during SEND discards the pending word
    data_rx_ready_i[4] = 1'b0;
    strobe(4'd4, 12'h444);
    repeat (3) tick();
    check("enfall_pending", 32'(data_rx_valid_o), 32'h10);
    cfg_rx_en_i[4] = 1'b0;
    tick();
    check("enfall_valid_off", 32'(data_rx_valid_o), 32'h0);
    check("enfall_drop_cnt", 32'(drop_cnt_o), 32'd1);
    cfg_rx_en_i[4]     = 1'b1;
    data_rx_ready_i[4] = 1'b1;
    clear_ovf();

    // Clear coinciding with a drop: drop wins
    data_rx_ready_i[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      expect_word(1, 32'h1000_00A0 | 32'(k));
      strobe(4'd1, 12'h0A0 + 12'(k));
    end
    strobe(4'd1, 12'h0A6);
    check("pre_clr_cnt", 32'(drop_cnt_o), 32'd1);
    ovf_clr_i = 1'b1;
    strobe(4'd1, 12'h0A7);
    ovf_clr_i = 1'b0;
    check("clr_drop_ovf", 32'(overflow_o), 32'd1);
    check("clr_drop_cnt1", 32'(drop_cnt_o), 32'd1);
    data_rx_ready_i[1] = 1'b1;
    drain(20);
    clear_ovf();

    // Asynchronous reset with one word in SEND and three buffered
    strobe(4'd9, 12'h999);
    tick();
    data_rx_ready_i[1] = 1'b0;
    for (int k = 0; k < 4; k++) strobe(4'd1, 12'h0B0 + 12'(k));
    tick();
    check("pre_rst_valid", 32'(data_rx_valid_o), 32'h02);
    check("pre_rst_cnt", 32'(drop_cnt_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_valid", 32'(data_rx_valid_o), 32'h0);
    check("arst_cnt", 32'(drop_cnt_o), 32'd0);
    check("arst_ovf", 32'(overflow_o), 32'd0);
    check("arst_data", 32'(data_rx_o == '0), 32'd1);
    sb_q.delete();
    data_rx_ready_i = '1;
    tick();
    tick();
    rstn_i = 1'b1;
    repeat (6) tick();
    check("post_rst_empty", 32'(data_rx_valid_o), 32'h0);
    check("post_rst_sb", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
